// File: rtl/ltsm_sb_pkg.sv
// Sideband message/info codes and the TX-arbiter state encoding.
// Shared by the PHYRETRAIN sideband arbiter and its helpers.
package ltsm_sb_pkg;

    localparam logic [3:0] PHYRETRAIN_START_REQ  = 4'd1;
    localparam logic [3:0] PHYRETRAIN_START_RESP = 4'd2;

    localparam logic [2:0] INFO_TXSELFCAL = 3'b001;
    localparam logic [2:0] INFO_SPEEDIDLE = 3'b010;
    localparam logic [2:0] INFO_REPAIR    = 3'b100;

    localparam logic [2:0] ARB_IDLE      = 3'd0;
    localparam logic [2:0] ARB_SEND      = 3'd1;
    localparam logic [2:0] ARB_WAIT_RISE = 3'd2;
    localparam logic [2:0] ARB_WAIT_FALL = 3'd3;
    localparam logic [2:0] ARB_DONE      = 3'd4;

endpackage

// File: rtl/sb_busy_edge_det.sv
// Registers sideband busy and flags its falling edge.
// o_fall is valid in the cycle busy first reads low; no backpressure.
module sb_busy_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_busy,
    output logic o_fall
);

    logic busy_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= i_busy;
        end
    end

    assign o_fall = busy_q & ~i_busy;

endmodule

// File: rtl/phyretrain_sb_tx_arbiter.sv
// Round-robin share of the sideband encoder between the PHYRETRAIN TX and RX FSMs.
// Valid -> o_sb_send +2 cycles; busy fall -> done pulse +1; requesters hold valid until the done pulse.
module phyretrain_sb_tx_arbiter
    import ltsm_sb_pkg::*;
#(
    parameter int unsigned SB_MSG_WIDTH = 4,
    parameter int unsigned INFO_WIDTH   = 3,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
    input  logic [INFO_WIDTH-1:0]   i_tx_msg_info,
    input  logic                    i_rx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
    input  logic [INFO_WIDTH-1:0]   i_rx_msg_info,
    input  logic                    i_sb_busy,
    output logic                    o_sb_send,
    output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
    output logic [INFO_WIDTH-1:0]   o_sb_msg_info,
    output logic                    o_tx_grant,
    output logic                    o_rx_grant,
    output logic                    o_falling_edge_busy,
    output logic                    o_rx_valid_fwd,
    output logic                    o_timeout_err
);

    localparam int unsigned      CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] rise_cnt;
    logic             last_rx;
    logic             busy_fall;
    logic             pick_rx;
    logic             pick_tx;

    sb_busy_edge_det u_busy_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_busy (i_sb_busy),
        .o_fall (busy_fall)
    );

    // On a tie the requester not served last wins; last_rx resets to TX so RX wins first.
    assign pick_rx = i_rx_valid & (~i_tx_valid | ~last_rx);
    assign pick_tx = i_tx_valid & ~pick_rx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state               <= ARB_IDLE;
            rise_cnt            <= '0;
            last_rx             <= 1'b0;
            o_sb_send           <= 1'b0;
            o_sb_msg            <= '0;
            o_sb_msg_info       <= '0;
            o_tx_grant          <= 1'b0;
            o_rx_grant          <= 1'b0;
            o_falling_edge_busy <= 1'b0;
            o_rx_valid_fwd      <= 1'b0;
            o_timeout_err       <= 1'b0;
        end else begin
            o_sb_send           <= 1'b0;
            o_falling_edge_busy <= 1'b0;
            o_timeout_err       <= 1'b0;
            o_rx_valid_fwd      <= i_rx_valid;
            case (state)
                ARB_IDLE: begin
                    if (pick_rx || pick_tx) begin
                        o_sb_msg      <= pick_rx ? i_rx_msg      : i_tx_msg;
                        o_sb_msg_info <= pick_rx ? i_rx_msg_info : i_tx_msg_info;
                        o_rx_grant    <= pick_rx;
                        o_tx_grant    <= pick_tx;
                        last_rx       <= pick_rx;
                        state         <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    o_sb_send <= 1'b1;
                    rise_cnt  <= '0;
                    state     <= ARB_WAIT_RISE;
                end
                ARB_WAIT_RISE: begin
                    if (i_sb_busy) begin
                        state <= ARB_WAIT_FALL;
                    end else if (rise_cnt == CNT_LAST) begin
                        // Encoder never started: release the grant so a held valid is re-arbitrated.
                        o_timeout_err <= 1'b1;
                        o_tx_grant    <= 1'b0;
                        o_rx_grant    <= 1'b0;
                        state         <= ARB_IDLE;
                    end else begin
                        rise_cnt <= rise_cnt + 1'b1;
                    end
                end
                ARB_WAIT_FALL: begin
                    if (busy_fall) begin
                        o_falling_edge_busy <= 1'b1;
                        state               <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    o_tx_grant <= 1'b0;
                    o_rx_grant <= 1'b0;
                    state      <= ARB_IDLE;
                end
                default: begin
                    o_tx_grant <= 1'b0;
                    o_rx_grant <= 1'b0;
                    state      <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phyretrain_sb_tx_arbiter.sv
// Bench for phyretrain_sb_tx_arbiter: encoder model answers each send with a busy burst,
// a scoreboard queue holds the expected message/owner of every send strobe.
module tb_phyretrain_sb_tx_arbiter;
    import ltsm_sb_pkg::*;

    typedef struct {
        logic [3:0] msg;
        logic [2:0] info;
        logic       is_rx;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_tx_valid = 1'b0;
    logic [3:0] i_tx_msg = '0;
    logic [2:0] i_tx_msg_info = '0;
    logic       i_rx_valid = 1'b0;
    logic [3:0] i_rx_msg = '0;
    logic [2:0] i_rx_msg_info = '0;
    logic       i_sb_busy = 1'b0;
    logic       o_sb_send;
    logic [3:0] o_sb_msg;
    logic [2:0] o_sb_msg_info;
    logic       o_tx_grant;
    logic       o_rx_grant;
    logic       o_falling_edge_busy;
    logic       o_rx_valid_fwd;
    logic       o_timeout_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   send_cnt = 0;
    int   fall_cnt = 0;
    int   to_cnt = 0;
    bit   enc_en = 1'b1;
    int   enc_len = 3;
    int   stray_req = 0;
    int   stray_done = 0;
    exp_t sb_q[$];

    phyretrain_sb_tx_arbiter #(
        .SB_MSG_WIDTH (4),
        .INFO_WIDTH   (3),
        .BUSY_TIMEOUT (16)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_tx_valid          (i_tx_valid),
        .i_tx_msg            (i_tx_msg),
        .i_tx_msg_info       (i_tx_msg_info),
        .i_rx_valid          (i_rx_valid),
        .i_rx_msg            (i_rx_msg),
        .i_rx_msg_info       (i_rx_msg_info),
        .i_sb_busy           (i_sb_busy),
        .o_sb_send           (o_sb_send),
        .o_sb_msg            (o_sb_msg),
        .o_sb_msg_info       (o_sb_msg_info),
        .o_tx_grant          (o_tx_grant),
        .o_rx_grant          (o_rx_grant),
        .o_falling_edge_busy (o_falling_edge_busy),
        .o_rx_valid_fwd      (o_rx_valid_fwd),
        .o_timeout_err       (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv_edge;
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp;
        @(negedge i_clk);
        #1;
    endtask

    task automatic wait_send(input string tag);
        int base = send_cnt;
        for (int i = 0; i < 40 && send_cnt == base; i++) smp();
        chk(tag, 32'(send_cnt != base), 32'd1);
    endtask

    task automatic wait_fall(input string tag);
        int base = fall_cnt;
        for (int i = 0; i < 40 && fall_cnt == base; i++) smp();
        chk(tag, 32'(fall_cnt != base), 32'd1);
    endtask

    // Sideband encoder model: busy rises the cycle after a send strobe and lasts enc_len cycles.
    initial begin : enc_model
        int n;
        forever begin
            @(negedge i_clk);
            n = 0;
            if (o_sb_send && enc_en) begin
                n = enc_len;
            end else if (stray_req != stray_done) begin
                stray_done = stray_req;
                n = 2;
            end
            if (n > 0) begin
                for (int k = 0; k < n; k++) begin
                    @(posedge i_clk);
                    #1 i_sb_busy = 1'b1;
                end
                @(posedge i_clk);
                #1 i_sb_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_falling_edge_busy) fall_cnt++;
            if (o_timeout_err) to_cnt++;
            if (o_sb_send) begin
                send_cnt++;
                chk("sb_expected_send", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_msg", 32'(o_sb_msg), 32'(e.msg));
                    chk("sb_info", 32'(o_sb_msg_info), 32'(e.info));
                    chk("sb_rx_grant", 32'(o_rx_grant), 32'(e.is_rx));
                    chk("sb_tx_grant", 32'(o_tx_grant), 32'(!e.is_rx));
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0, f0, t0, n;
        #2 i_rst = 1'b1;
        #1;
        chk("rst_outputs", 32'({o_sb_send, o_sb_msg, o_sb_msg_info, o_tx_grant, o_rx_grant,
                                o_falling_edge_busy, o_rx_valid_fwd, o_timeout_err}), 32'd0);
        drv_edge();
        drv_edge();
        i_rst = 1'b0;

        // 1: single TX request, latency and grant hold
        f0 = fall_cnt;
        drv_edge();
        i_tx_valid = 1'b1; i_tx_msg = PHYRETRAIN_START_REQ; i_tx_msg_info = INFO_TXSELFCAL;
        sb_q.push_back('{PHYRETRAIN_START_REQ, INFO_TXSELFCAL, 1'b0});
        smp();
        chk("t1_grant_c0", 32'(o_tx_grant), 32'd0);
        chk("t1_send_c0", 32'(o_sb_send), 32'd0);
        smp();
        chk("t1_send_c1", 32'(o_sb_send), 32'd0);
        chk("t1_grant_c1", 32'(o_tx_grant), 32'd1);
        smp();
        chk("t1_send_c2", 32'(o_sb_send), 32'd1);
        wait_fall("t1_fall");
        chk("t1_grant_done", 32'(o_tx_grant), 32'd1);
        drv_edge();
        i_tx_valid = 1'b0;
        smp();
        chk("t1_grant_off", 32'(o_tx_grant), 32'd0);
        repeat (5) smp();
        chk("t1_fall_count", 32'(fall_cnt - f0), 32'd1);

        // 2: tie after reset goes to RX, then both held high alternate
        s0 = send_cnt;
        drv_edge();
        i_tx_valid = 1'b1; i_tx_msg = PHYRETRAIN_START_REQ;  i_tx_msg_info = INFO_TXSELFCAL;
        i_rx_valid = 1'b1; i_rx_msg = PHYRETRAIN_START_RESP; i_rx_msg_info = INFO_SPEEDIDLE;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb_q.push_back('{PHYRETRAIN_START_RESP, INFO_SPEEDIDLE, 1'b1});
            else            sb_q.push_back('{PHYRETRAIN_START_REQ, INFO_TXSELFCAL, 1'b0});
        end
        for (int k = 0; k < 4; k++) wait_fall("t2_fall");
        drv_edge();
        i_tx_valid = 1'b0; i_rx_valid = 1'b0;
        repeat (5) smp();
        chk("t2_send_count", 32'(send_cnt - s0), 32'd4);

        // 3: busy never rises -> timeout, then re-arbitration of the held valid
        t0 = to_cnt;
        enc_en = 1'b0;
        drv_edge();
        i_tx_valid = 1'b1; i_tx_msg = PHYRETRAIN_START_REQ; i_tx_msg_info = INFO_REPAIR;
        sb_q.push_back('{PHYRETRAIN_START_REQ, INFO_REPAIR, 1'b0});
        sb_q.push_back('{PHYRETRAIN_START_REQ, INFO_REPAIR, 1'b0});
        wait_send("t3_send1");
        n = 0;
        for (int i = 1; i <= 40 && to_cnt == t0; i++) begin
            smp();
            n = i;
        end
        chk("t3_to_latency", 32'(n), 32'd16);
        chk("t3_to_grant", 32'(o_tx_grant), 32'd0);
        enc_en = 1'b1;
        smp();
        chk("t3_to_one_cycle", 32'(o_timeout_err), 32'd0);
        wait_send("t3_send2");
        wait_fall("t3_fall");
        drv_edge();
        i_tx_valid = 1'b0;
        repeat (4) smp();
        chk("t3_to_count", 32'(to_cnt - t0), 32'd1);

        // 4: RX drops valid and changes msg mid-transfer; latched message survives
        s0 = send_cnt; f0 = fall_cnt;
        enc_len = 4;
        drv_edge();
        i_rx_valid = 1'b1; i_rx_msg = PHYRETRAIN_START_RESP; i_rx_msg_info = INFO_SPEEDIDLE;
        sb_q.push_back('{PHYRETRAIN_START_RESP, INFO_SPEEDIDLE, 1'b1});
        smp();
        chk("t4_fwd_c0", 32'(o_rx_valid_fwd), 32'd0);
        smp();
        chk("t4_fwd_c1", 32'(o_rx_valid_fwd), 32'd1);
        wait_send("t4_send");
        smp();
        smp();
        drv_edge();
        i_rx_valid = 1'b0; i_rx_msg = 4'hF; i_rx_msg_info = 3'b111;
        smp();
        chk("t4_msg_held", 32'(o_sb_msg), 32'(PHYRETRAIN_START_RESP));
        chk("t4_info_held", 32'(o_sb_msg_info), 32'(INFO_SPEEDIDLE));
        chk("t4_grant_held", 32'(o_rx_grant), 32'd1);
        wait_fall("t4_fall");
        chk("t4_msg_done", 32'(o_sb_msg), 32'(PHYRETRAIN_START_RESP));
        repeat (6) smp();
        chk("t4_send_count", 32'(send_cnt - s0), 32'd1);
        chk("t4_fall_count", 32'(fall_cnt - f0), 32'd1);
        chk("t4_fwd_low", 32'(o_rx_valid_fwd), 32'd0);

        // 5: asynchronous reset while waiting for busy to fall
        enc_len = 6;
        drv_edge();
        i_tx_valid = 1'b1; i_tx_msg = PHYRETRAIN_START_REQ; i_tx_msg_info = INFO_TXSELFCAL;
        sb_q.push_back('{PHYRETRAIN_START_REQ, INFO_TXSELFCAL, 1'b0});
        wait_send("t5_send");
        smp();
        smp();
        s0 = send_cnt; f0 = fall_cnt;
        #1 i_rst = 1'b1;
        #1;
        chk("t5_rst_outputs", 32'({o_sb_send, o_sb_msg, o_sb_msg_info, o_tx_grant, o_rx_grant,
                                   o_falling_edge_busy, o_rx_valid_fwd, o_timeout_err}), 32'd0);
        i_tx_valid = 1'b0;
        drv_edge();
        drv_edge();
        i_rst = 1'b0;
        repeat (12) smp();
        chk("t5_no_send", 32'(send_cnt - s0), 32'd0);
        chk("t5_no_fall", 32'(fall_cnt - f0), 32'd0);
        chk("t5_idle_grant", 32'({o_tx_grant, o_rx_grant}), 32'd0);

        // 6: stray busy pulse with no requester
        s0 = send_cnt; f0 = fall_cnt;
        stray_req++;
        repeat (10) smp();
        chk("t6_no_fall", 32'(fall_cnt - f0), 32'd0);
        chk("t6_no_send", 32'(send_cnt - s0), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
